// File: rtl/sha1_stream.sv
// sha1_stream: multi-block SHA-1 compression engine, ROUNDS_PER_CYCLE rounds per clock, chained H0..H4.
// Optional completed-block counter port present when SHA1_BLOCK_CNT_EN is defined.
module sha1_stream #(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int CNT_WIDTH        = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 block_valid,
  output logic                 block_ready,
  input  logic [511:0]         block_data,
  input  logic                 block_first,
  input  logic                 block_last,
  output logic                 digest_valid,
  input  logic                 digest_ready,
  output logic [159:0]         digest,
  output logic                 busy,
  output logic [6:0]           idx
`ifdef SHA1_BLOCK_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] block_cnt
`endif
);

  localparam logic [6:0]   R7 = 7'(ROUNDS_PER_CYCLE);
  localparam logic [159:0] IV = {32'h67452301, 32'hEFCDAB89, 32'h98BADCFE, 32'h10325476, 32'hC3D2E1F0};

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
        ROUNDS_PER_CYCLE == 4 || ROUNDS_PER_CYCLE == 5)) begin : g_bad_rounds
    $error("sha1_stream: ROUNDS_PER_CYCLE must be 1, 2, 4 or 5");
  end
  if (CNT_WIDTH < 1) begin : g_bad_cnt
    $error("sha1_stream: CNT_WIDTH must be at least 1");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_ROUND, ST_UPDATE, ST_OUT} state_t;

  state_t         state_r, state_s;
  logic [31:0]    w_r [16];
  logic [31:0]    win_s [16];
  logic [31:0]    wnew_s;
  logic [31:0]    a_r, b_r, c_r, d_r, e_r;
  logic [159:0]   h_r;
  logic [159:0]   abcde_s;
  logic [159:0]   sum_s;
  logic [159:0]   init_s;
  logic [159:0]   digest_r;
  logic [6:0]     idx_r;
  logic           last_r, chain_r, block_ready_r, digest_valid_r, busy_r;
  logic           accept_s, last_round_s;

  function automatic logic [31:0] rotl1(input logic [31:0] x);
    return {x[30:0], x[31]};
  endfunction

  function automatic logic [31:0] rotl5(input logic [31:0] x);
    return {x[26:0], x[31:27]};
  endfunction

  function automatic logic [31:0] rotl30(input logic [31:0] x);
    return {x[1:0], x[31:2]};
  endfunction

  // One SHA-1 round on the packed {a,b,c,d,e} state for round index t.
  function automatic logic [159:0] sha1_round(input logic [159:0] s, input logic [6:0] t,
                                              input logic [31:0] w);
    logic [31:0] a, b, c, d, e, f, k;
    {a, b, c, d, e} = s;
    if (t < 7'd20) begin
      f = (b & c) | (~b & d);
      k = 32'h5A827999;
    end else if (t < 7'd40) begin
      f = b ^ c ^ d;
      k = 32'h6ED9EBA1;
    end else if (t < 7'd60) begin
      f = (b & c) | (b & d) | (c & d);
      k = 32'h8F1BBCDC;
    end else begin
      f = b ^ c ^ d;
      k = 32'hCA62C1D6;
    end
    return {rotl5(a) + f + e + k + w, a, rotl30(b), c, d};
  endfunction

  assign accept_s     = (state_r == ST_IDLE) && block_valid && block_ready_r;
  assign last_round_s = (idx_r == (7'd80 - R7));
  assign init_s       = (block_first || !chain_r) ? IV : h_r;
  assign sum_s        = {h_r[159:128] + a_r, h_r[127:96] + b_r, h_r[95:64] + c_r,
                         h_r[63:32] + d_r, h_r[31:0] + e_r};

  // Unrolled rounds; the window slides one word per round, W[t+16] appended at the top.
  always_comb begin
    abcde_s = {a_r, b_r, c_r, d_r, e_r};
    wnew_s  = 32'h0;
    for (int i = 0; i < 16; i++) win_s[i] = w_r[i];
    for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
      abcde_s = sha1_round(abcde_s, idx_r + 7'(j), win_s[0]);
      wnew_s  = rotl1(win_s[13] ^ win_s[8] ^ win_s[2] ^ win_s[0]);
      for (int i = 0; i < 15; i++) win_s[i] = win_s[i+1];
      win_s[15] = wnew_s;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= ST_IDLE;
    else        state_r <= state_s;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:   if (accept_s) state_s = ST_ROUND;  else state_s = ST_IDLE;
      ST_ROUND:  if (last_round_s) state_s = ST_UPDATE; else state_s = ST_ROUND;
      ST_UPDATE: if (last_r) state_s = ST_OUT; else state_s = ST_IDLE;
      ST_OUT:    if (digest_ready) state_s = ST_IDLE; else state_s = ST_OUT;
      default:   state_s = ST_IDLE;
    endcase
  end

  // Datapath, chaining values and handshake registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) w_r[i] <= 32'h0;
      a_r <= 32'h0; b_r <= 32'h0; c_r <= 32'h0; d_r <= 32'h0; e_r <= 32'h0;
      h_r            <= 160'h0;
      digest_r       <= 160'h0;
      idx_r          <= 7'd0;
      last_r         <= 1'b0;
      chain_r        <= 1'b0;
      block_ready_r  <= 1'b0;
      digest_valid_r <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            for (int i = 0; i < 16; i++) w_r[i] <= block_data[511-32*i -: 32];
            {a_r, b_r, c_r, d_r, e_r} <= init_s;
            h_r           <= init_s;
            last_r        <= block_last;
            idx_r         <= 7'd0;
            block_ready_r <= 1'b0;
            busy_r        <= 1'b1;
          end else begin
            block_ready_r <= 1'b1;
          end
        end
        ST_ROUND: begin
          {a_r, b_r, c_r, d_r, e_r} <= abcde_s;
          for (int i = 0; i < 16; i++) w_r[i] <= win_s[i];
          if (last_round_s) idx_r <= 7'd0;
          else              idx_r <= idx_r + R7;
        end
        ST_UPDATE: begin
          h_r    <= sum_s;
          busy_r <= 1'b0;
          if (last_r) begin
            digest_r       <= sum_s;
            digest_valid_r <= 1'b1;
            chain_r        <= 1'b0;
          end else begin
            chain_r       <= 1'b1;
            block_ready_r <= 1'b1;
          end
        end
        ST_OUT: begin
          if (digest_ready) begin
            digest_valid_r <= 1'b0;
            block_ready_r  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SHA1_BLOCK_CNT_EN
  logic [CNT_WIDTH-1:0] block_cnt_r;

  // Completed-block counter, wraps naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                   block_cnt_r <= '0;
    else if (state_r == ST_UPDATE) block_cnt_r <= block_cnt_r + CNT_WIDTH'(1);
    else                          block_cnt_r <= block_cnt_r;
  end

  assign block_cnt = block_cnt_r;
`endif

  assign block_ready  = block_ready_r;
  assign digest_valid = digest_valid_r;
  assign digest       = digest_r;
  assign busy         = busy_r;
  assign idx          = idx_r;

endmodule

// File: tb/tb_sha1_stream.sv
// Self-checking bench for sha1_stream: known vectors, latency, backpressure, mid-run reset, random chains.
module tb_sha1_stream;

  localparam int R   = 1;
  localparam int LAT = 80 / R + 1;
  localparam logic [159:0] IV = {32'h67452301, 32'hEFCDAB89, 32'h98BADCFE, 32'h10325476, 32'hC3D2E1F0};

  logic         clk = 1'b0;
  logic         reset;
  logic         block_valid, block_ready, block_first, block_last;
  logic [511:0] block_data;
  logic         digest_valid, digest_ready, busy;
  logic [159:0] digest;
  logic [6:0]   idx;
`ifdef SHA1_BLOCK_CNT_EN
  logic [31:0]  block_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  logic [159:0] m_h;
  logic [159:0] m_dig;
  logic         m_chain;
  int           m_cnt;

  sha1_stream #(.ROUNDS_PER_CYCLE(R), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .block_valid(block_valid), .block_ready(block_ready), .block_data(block_data),
    .block_first(block_first), .block_last(block_last),
    .digest_valid(digest_valid), .digest_ready(digest_ready), .digest(digest),
    .busy(busy), .idx(idx)
`ifdef SHA1_BLOCK_CNT_EN
    , .block_cnt(block_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Textbook SHA-1 compression with a full 80-word schedule.
  function automatic logic [159:0] ref_compress(input logic [159:0] h, input logic [511:0] blk);
    logic [31:0] w [80];
    logic [31:0] a, b, c, d, e, f, k, tmp;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 80; t++) w[t] = rol(w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16], 1);
    {a, b, c, d, e} = h;
    for (int t = 0; t < 80; t++) begin
      case (t / 20)
        0:       begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
        1:       begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
        2:       begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
        default: begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
      endcase
      tmp = rol(a, 5) + f + e + k + w[t];
      e = d; d = c; c = rol(b, 30); b = a; a = tmp;
    end
    return {h[159:128] + a, h[127:96] + b, h[95:64] + c, h[63:32] + d, h[31:0] + e};
  endfunction

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!block_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", {159'd0, block_ready}, 160'd1);
  endtask

  task automatic send_block(input logic [511:0] d, input logic f, input logic l);
    int n = 0;
    wait_ready();
    block_valid = 1'b1; block_data = d; block_first = f; block_last = l;
    @(negedge clk);
    block_valid = 1'b0;
    block_data  = {16{$urandom()}};
    if (f || !m_chain) m_h = IV;
    m_h = ref_compress(m_h, d);
    if (l) begin m_dig = m_h; m_chain = 1'b0; end
    else   m_chain = 1'b1;
    m_cnt++;
    chk("busy_on", {159'd0, busy}, 160'd1);
    chk("ready_low", {159'd0, block_ready}, 160'd0);
    while (!(l ? digest_valid : block_ready) && n < 300) begin
      @(negedge clk);
      n++;
      if (n == 10) chk("idx10", {153'd0, idx}, 160'(10 * R));
    end
    chk("latency", 160'(n), 160'(LAT));
    chk("busy_off", {159'd0, busy}, 160'd0);
`ifdef SHA1_BLOCK_CNT_EN
    chk("block_cnt", {128'd0, block_cnt}, 160'(m_cnt));
`endif
  endtask

  task automatic take_digest(input int hold);
    chk("digest", digest, m_dig);
    for (int i = 0; i < hold; i++) begin
      block_valid = 1'b1; block_data = {16{$urandom()}}; block_first = 1'b1; block_last = 1'b1;
      @(negedge clk);
      chk("bp_digest", digest, m_dig);
      chk("bp_valid", {159'd0, digest_valid}, 160'd1);
      chk("bp_ready", {159'd0, block_ready}, 160'd0);
    end
    block_valid  = 1'b0;
    digest_ready = 1'b1;
    @(negedge clk);
    digest_ready = 1'b0;
    chk("take_valid", {159'd0, digest_valid}, 160'd0);
    chk("take_ready", {159'd0, block_ready}, 160'd1);
    chk("take_keep", digest, m_dig);
  endtask

  logic [511:0] abc_blk, empty_blk, two1_blk, two2_blk, rnd_blk;
  int nb, n;
  logic f;

  initial begin
    abc_blk   = {32'h61626380, 448'd0, 32'h00000018};
    empty_blk = {32'h80000000, 480'd0};
    two1_blk  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    two2_blk  = {480'd0, 32'h000001c0};
    m_h = 160'd0; m_dig = 160'd0; m_chain = 1'b0; m_cnt = 0;
    reset = 1'b1; block_valid = 1'b0; block_data = 512'd0; block_first = 1'b0;
    block_last = 1'b0; digest_ready = 1'b0;

    #3 reset = 1'b0;
    #4;
    chk("rst_ready", {159'd0, block_ready}, 160'd0);
    chk("rst_valid", {159'd0, digest_valid}, 160'd0);
    chk("rst_digest", digest, 160'd0);
    chk("rst_busy", {159'd0, busy}, 160'd0);
    chk("rst_idx", {153'd0, idx}, 160'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1 chk("ready_pre", {159'd0, block_ready}, 160'd0);
    @(negedge clk);
    chk("ready_post", {159'd0, block_ready}, 160'd1);

    send_block(abc_blk, 1'b1, 1'b1);
    take_digest(10);
    chk("abc_const", digest, 160'ha9993e364706816aba3e25717850c26c9cd0d89d);

    // first=0 with no chain behaves as first
    send_block(empty_blk, 1'b0, 1'b1);
    take_digest(0);
    chk("empty_const", digest, 160'hda39a3ee5e6b4b0d3255bfef95601890afd80709);

    send_block(two1_blk, 1'b1, 1'b0);
    send_block(two2_blk, 1'b0, 1'b1);
    take_digest(2);
    chk("two_const", digest, 160'h84983e441c3bd26ebaae4aa1f95129e5e54670f1);

    // first=1 mid-chain discards the chain
    send_block(two1_blk, 1'b1, 1'b0);
    send_block(abc_blk, 1'b1, 1'b1);
    take_digest(1);
    chk("restart_const", digest, 160'ha9993e364706816aba3e25717850c26c9cd0d89d);

    // reset in the middle of the rounds
    wait_ready();
    block_valid = 1'b1; block_data = abc_blk; block_first = 1'b1; block_last = 1'b1;
    @(negedge clk);
    block_valid = 1'b0;
    n = 0;
    while (idx != 7'd40 && n < 200) begin @(negedge clk); n++; end
    chk("idx40_seen", {153'd0, idx}, 160'd40);
    reset = 1'b0;
    #1;
    chk("mid_ready", {159'd0, block_ready}, 160'd0);
    chk("mid_valid", {159'd0, digest_valid}, 160'd0);
    chk("mid_digest", digest, 160'd0);
    chk("mid_busy", {159'd0, busy}, 160'd0);
    chk("mid_idx", {153'd0, idx}, 160'd0);
    m_chain = 1'b0; m_cnt = 0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send_block(abc_blk, 1'b1, 1'b1);
    take_digest(0);
    chk("abc_again", digest, 160'ha9993e364706816aba3e25717850c26c9cd0d89d);
`ifdef SHA1_BLOCK_CNT_EN
    chk("cnt_after_rst", {128'd0, block_cnt}, 160'd1);
`endif

    // random multi-block messages against the reference model
    for (int m = 0; m < 6; m++) begin
      nb = $urandom_range(1, 3);
      for (int b = 0; b < nb; b++) begin
        for (int i = 0; i < 16; i++) rnd_blk[511-32*i -: 32] = $urandom();
        f = (b == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
        send_block(rnd_blk, f, (b == nb - 1));
      end
      take_digest($urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
